jk_sync_counter: RTL and testbench
==================================

Name: jk_sync_counter

Overview:
- Parametrised successor to the single-bit synchronous JK flip-flop: a WIDTH-bit register built from per-bit JK cells.
- Operates either as a raw JK register bank (per-bit J/K vectors) or as an up/down/loadable counter.
- Provides a terminal-count flag and a registered wrap pulse.
- Used as the general counter/state-register primitive for timers and dividers in lab designs.

Parameters:
- WIDTH, 4, number of bits in the register (>=1).
- RESET_VAL, 0, value loaded into q on s_reset (WIDTH bits).
- MOD_VAL, 10, modulus used only when JK_CNT_MOD_EN is defined (2..2^WIDTH).

Ports:
- clk1  input  1  clock; all state changes on its rising edge.
- s_reset  input  1  synchronous active-high reset.
- en  input  1  update enable; 0 = hold all state.
- mode  input  2  operation select: 00 JK, 01 UP, 10 DOWN, 11 LOAD.
- j  input  WIDTH  per-bit J inputs (JK mode only).
- k  input  WIDTH  per-bit K inputs (JK mode only).
- d  input  WIDTH  parallel load data (LOAD mode only).
- q  output  WIDTH  register state.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse following a counter wrap.

Behaviour:
- Reset: synchronous, active-high. On a clk1 edge with s_reset=1: q=RESET_VAL, wrap=0. Reset has priority over en and mode. Reset mid-count aborts the count with no wrap pulse.
- en=0: q and wrap hold their current values, except wrap clears to 0 (wrap is a pulse).
- JK mode (00), en=1, per bit i:
  - j=0,k=0: hold.
  - j=1,k=0: set.
  - j=0,k=1: clear.
  - j=1,k=1: toggle.
  - wrap=0.
- UP mode (01), en=1: q <= q+1 modulo 2^WIDTH. Per-bit JK drive J=K=AND of all lower bits (bit0 J=K=1). When q==all-ones the next q=0 and wrap=1 on that same edge (visible the cycle after the wrapping edge).
- DOWN mode (10), en=1: q <= q-1 modulo 2^WIDTH. J=K=AND of the inverted lower bits. When q==0 the next q=all-ones and wrap=1.
- LOAD mode (11), en=1: q <= d via J=d[i], K=~d[i]; wrap=0.
- tc:
  - 1 when mode=UP and q==max value.
  - 1 when mode=DOWN and q==0.
  - 0 otherwise.
  - Independent of en.
- Latency: one clk1 cycle from inputs to q. wrap asserts in the same cycle as the wrapped q value.
- All next-state logic routes through the JK cells. No direct D assignment of q outside the cells.

Optional Feature:
- Macro: JK_CNT_MOD_EN.
- Defined:
  - Counter is modulo MOD_VAL. UP wraps MOD_VAL-1 -> 0; DOWN wraps 0 -> MOD_VAL-1. wrap pulses at each wrap.
  - tc in UP mode asserts at q==MOD_VAL-1.
  - LOAD values >= MOD_VAL are clamped to MOD_VAL-1.
  - JK mode is unrestricted. If JK mode leaves q >= MOD_VAL, the next UP step goes to 0 with wrap=1.
- Undefined: full 2^WIDTH wrap. MOD_VAL is ignored.

Decomposition:
- Shared package jk_pkg:
  - Mode encodings: JK_MODE_JK=2'b00, JK_MODE_UP=2'b01, JK_MODE_DOWN=2'b10, JK_MODE_LOAD=2'b11.
  - Typedef jk_mode_t for the 2-bit mode.
- Sub-module jk_cell: 1-bit JK flip-flop with synchronous active-high reset, clock enable, and parameter RST_VAL. Instantiate WIDTH copies via generate.
- Top level holds the J/K steering logic, tc, and the wrap register.

Test Plan (WIDTH=4 unless noted):
- Reset: s_reset=1 for 1 cycle with RESET_VAL=4'h5, en=1, mode=UP -> q=4'h5, wrap=0. Reset wins over the count.
- JK mode: q=4'b1010, j=4'b0101, k=4'b1000, en=1 -> q=4'b0111 after one edge. Then j=k=4'b1111 -> q=4'b1000.
- UP wrap: load 4'hE, then UP for 3 cycles -> q sequence F,0,1. tc=1 while q=F. wrap=1 only in the cycle q=0.
- DOWN wrap and en hold: load 4'h1, DOWN -> 0,F with wrap on F. Then en=0 for 3 cycles -> q stays F, wrap=0.
- Reset mid-operation: counting UP at q=7, assert s_reset -> q=RESET_VAL next edge, no wrap. Deassert -> counting resumes from RESET_VAL.
- JK_CNT_MOD_EN, MOD_VAL=10:
  - UP from 8 -> 9,0 with wrap=1 at 0 and tc=1 at 9.
  - DOWN from 0 -> 9.
  - LOAD d=4'hC -> q=9.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and encodings for the JK-cell counter family.
// Latency: none (declarations only).
// Backpressure: none; no handshake is involved.
package jk_pkg;

    // Operation select carried on the 2-bit mode input
    typedef enum logic [1:0] {
        JK_MODE_JK   = 2'b00,
        JK_MODE_UP   = 2'b01,
        JK_MODE_DOWN = 2'b10,
        JK_MODE_LOAD = 2'b11
    } jk_mode_t;

    // Characteristic equation of a JK flip-flop, handy for anyone reasoning about the cells
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset and clock enable.
// Latency: one clk edge from j/k to q.
// Backpressure: ce=0 holds the stored bit; there is no other stall path.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic s_reset,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q
);

    // Reset wins, then enable gates the hold/set/clear/toggle behaviour
    always_ff @(posedge clk) begin
        if (s_reset) begin
            q <= RST_VAL;
        end else if (ce) begin
            q <= jk_next(q, j, k);
        end
    end

endmodule

// File: rtl/jk_sync_counter.sv
// WIDTH-bit JK register bank / up-down-load counter with terminal count and wrap pulse.
// Latency: one clk1 edge to q; wrap shows in the same cycle as the wrapped q; tc is combinational.
// Backpressure: en=0 freezes q and clears wrap. Optional modulo counting via macro JK_CNT_MOD_EN.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               MOD_VAL   = 10
) (
    input  logic             clk1,
    input  logic             s_reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

`ifdef JK_CNT_MOD_EN
    localparam bit MOD_EN = 1'b1;
`else
    localparam bit MOD_EN = 1'b0;
`endif

    // Highest value the counter reaches before wrapping: MOD_VAL-1 in modulo
    // builds, all-ones otherwise. Every wrap/clamp check below compares against it,
    // so the full-range build is just the special case CNT_TOP == '1.
    localparam logic [WIDTH-1:0] MOD_TOP = WIDTH'(MOD_VAL - 1);
    localparam logic [WIDTH-1:0] CNT_TOP = MOD_EN ? MOD_TOP : {WIDTH{1'b1}};

    jk_mode_t          mode_e;
    logic [WIDTH-1:0]  q_int;
    logic [WIDTH-1:0]  j_drv;
    logic [WIDTH-1:0]  k_drv;
    logic [WIDTH-1:0]  up_tgl;
    logic [WIDTH-1:0]  dn_tgl;
    logic [WIDTH-1:0]  ld_val;
    logic              up_wrap;
    logic              dn_wrap;
    logic              wrap_nxt;

    assign mode_e = jk_mode_t'(mode);
    assign q      = q_int;

    // Toggle enables for binary increment/decrement: a bit flips when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        up_tgl    = '0;
        dn_tgl    = '0;
        up_tgl[0] = 1'b1;
        dn_tgl[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_tgl[i] = up_tgl[i-1] & q_int[i-1];
            dn_tgl[i] = dn_tgl[i-1] & ~q_int[i-1];
        end
    end

    // Wrap detection and load clamping; ">=" also catches out-of-range values left by JK mode
    always_comb begin
        up_wrap = (q_int >= CNT_TOP);
        dn_wrap = (q_int == '0);
        ld_val  = (d > CNT_TOP) ? CNT_TOP : d;
    end

    // J/K steering per mode; every next-state value is produced through the cells
    always_comb begin
        j_drv    = '0;
        k_drv    = '0;
        wrap_nxt = 1'b0;
        unique case (mode_e)
            JK_MODE_JK: begin
                j_drv = j;
                k_drv = k;
            end
            JK_MODE_UP: begin
                if (up_wrap) begin
                    // Clear every bit to land on zero
                    j_drv    = '0;
                    k_drv    = '1;
                    wrap_nxt = 1'b1;
                end else begin
                    j_drv = up_tgl;
                    k_drv = up_tgl;
                end
            end
            JK_MODE_DOWN: begin
                if (dn_wrap) begin
                    // Force the top value in a single step
                    j_drv    = CNT_TOP;
                    k_drv    = ~CNT_TOP;
                    wrap_nxt = 1'b1;
                end else begin
                    j_drv = dn_tgl;
                    k_drv = dn_tgl;
                end
            end
            JK_MODE_LOAD: begin
                j_drv = ld_val;
                k_drv = ~ld_val;
            end
            default: begin
                j_drv = '0;
                k_drv = '0;
            end
        endcase
    end

    // Terminal count looks only at mode and q, never at en
    always_comb begin
        tc = 1'b0;
        if (mode_e == JK_MODE_UP && q_int == CNT_TOP) begin
            tc = 1'b1;
        end else if (mode_e == JK_MODE_DOWN && q_int == '0) begin
            tc = 1'b1;
        end
    end

    // One JK cell per bit, each with its own slice of the reset value
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(
            .RST_VAL (RESET_VAL[gi])
        ) u_cell (
            .clk     (clk1),
            .s_reset (s_reset),
            .ce      (en),
            .j       (j_drv[gi]),
            .k       (k_drv[gi]),
            .q       (q_int[gi])
        );
    end

    // Wrap pulse register: one cycle high after a wrapping edge, low whenever idle or reset
    always_ff @(posedge clk1) begin
        if (s_reset) begin
            wrap <= 1'b0;
        end else if (en) begin
            wrap <= wrap_nxt;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter (WIDTH=4, RESET_VAL=5, MOD_VAL=10).
// Latency: checks q/wrap one edge after each input set; tc checked before the edge.
// Backpressure: exercises en=0 hold periods; honours JK_CNT_MOD_EN when defined.
module tb_jk_sync_counter;

    localparam int W = 4;
`ifdef JK_CNT_MOD_EN
    localparam int M = 10;
`else
    localparam int M = 16;
`endif

    logic         clk1;
    logic         s_reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j, k, d;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [W-1:0] m_q;
    logic         m_wrap;
    bit           m_known = 0;

    jk_sync_counter #(
        .WIDTH     (W),
        .RESET_VAL (4'h5),
        .MOD_VAL   (10)
    ) dut (
        .clk1    (clk1),
        .s_reset (s_reset),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .d       (d),
        .q       (q),
        .tc      (tc),
        .wrap    (wrap)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: counter arithmetic over modulus M, JK via its truth table
    function automatic logic model_tc(input logic [1:0] md, input logic [W-1:0] cq);
        if (md == 2'b01) return (int'(cq) == M - 1);
        if (md == 2'b10) return (cq == 0);
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [W-1:0] nq;
        logic         nw;
        nq = m_q;
        nw = 1'b0;
        if (s_reset) begin
            nq = 4'h5;
        end else if (en) begin
            case (mode)
                2'b00: for (int b = 0; b < W; b++) begin
                    case ({j[b], k[b]})
                        2'b10: nq[b] = 1'b1;
                        2'b01: nq[b] = 1'b0;
                        2'b11: nq[b] = ~m_q[b];
                        default: nq[b] = m_q[b];
                    endcase
                end
                2'b01: if (int'(m_q) >= M - 1) begin nq = 0; nw = 1'b1; end
                       else nq = W'(int'(m_q) + 1);
                2'b10: if (m_q == 0) begin nq = W'(M - 1); nw = 1'b1; end
                       else nq = W'(int'(m_q) - 1);
                default: nq = (int'(d) >= M) ? W'(M - 1) : d;
            endcase
        end
        m_q     = nq;
        m_wrap  = nw;
        m_known = 1;
    endtask

    // One clock: drive at negedge, check tc, take the edge, check q and wrap
    task automatic step(input logic rst, input logic e, input logic [1:0] md,
                        input logic [W-1:0] jj, input logic [W-1:0] kk, input logic [W-1:0] dd,
                        input string tag);
        @(negedge clk1);
        s_reset = rst; en = e; mode = md; j = jj; k = kk; d = dd;
        #1;
        if (m_known) check({tag, ".tc"}, W'(tc), W'(model_tc(md, m_q)));
        @(posedge clk1);
        model_step();
        #1;
        check({tag, ".q"}, q, m_q);
        check({tag, ".wrap"}, W'(wrap), W'(m_wrap));
    endtask

    initial begin
        s_reset = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;

        // Reset beats an enabled UP count
        step(1, 1, 2'b01, 0, 0, 0, "reset");
        check("reset_lit", q, 4'h5);

        // JK mode: force 1010, then hold/set/clear mix, then all toggle
        step(0, 1, 2'b00, 4'hA, 4'h5, 0, "jk_set");
        step(0, 1, 2'b00, 4'h5, 4'h8, 0, "jk_mix");
        check("jk_mix_lit", q, 4'b0111);
        step(0, 1, 2'b00, 4'hF, 4'hF, 0, "jk_tgl");
        check("jk_tgl_lit", q, 4'b1000);

        // UP wrap from E (clamped in modulo builds)
        step(0, 1, 2'b11, 0, 0, 4'hE, "up_ld");
        for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 0, 0, 0, "up_run");
`ifndef JK_CNT_MOD_EN
        check("up_lit", q, 4'h1);
`endif

        // DOWN wrap then enable low hold
        step(0, 1, 2'b11, 0, 0, 4'h1, "dn_ld");
        step(0, 1, 2'b10, 0, 0, 0, "dn_0");
        step(0, 1, 2'b10, 0, 0, 0, "dn_wrap");
        check("dn_wrap_lit", W'(wrap), 4'h1);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b10, 0, 0, 0, "hold");
        check("hold_lit", q, W'(M - 1));

        // Reset in the middle of counting, then resume
        step(0, 1, 2'b11, 0, 0, 4'h7, "mid_ld");
        step(1, 1, 2'b01, 0, 0, 0, "mid_rst");
        step(0, 1, 2'b01, 0, 0, 0, "mid_resume");
        check("mid_resume_lit", q, 4'h6);

        // Modulo-specific corners (model covers both builds)
        step(0, 1, 2'b11, 0, 0, 4'h8, "mod_ld8");
        step(0, 1, 2'b01, 0, 0, 0, "mod_up9");
        step(0, 1, 2'b01, 0, 0, 0, "mod_up0");
        step(0, 1, 2'b11, 0, 0, 4'h0, "mod_ld0");
        step(0, 1, 2'b10, 0, 0, 0, "mod_dn");
        step(0, 1, 2'b11, 0, 0, 4'hC, "mod_ldc");
        step(0, 1, 2'b00, 4'hC, 4'h3, 0, "mod_jkc");
        step(0, 1, 2'b01, 0, 0, 0, "mod_upc");
`ifdef JK_CNT_MOD_EN
        check("mod_upc_lit", q, 4'h0);
`endif

        // Random traffic against the reference
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
